// File: rtl/sdram_memtest_pkg.sv
// sdram_memtest_pkg: shared state encoding, pattern mode codes and LFSR step
package sdram_memtest_pkg;
  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, CHECK, DONE} state_t;
  localparam logic [1:0] MODE_ADDR = 2'd0;
  localparam logic [1:0] MODE_NADDR = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;
  localparam logic [1:0] MODE_WALK = 2'd3;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction
endpackage

// File: rtl/sdram_memtest_pattern.sv
// sdram_memtest_pattern: LFSR sequence register and per-address test word generator
module sdram_memtest_pattern
  import sdram_memtest_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        seed_load,
  input  logic        step,
  input  logic [15:0] addr,
  input  logic [1:0]  mode,
  input  logic        invert,
  output logic [15:0] pattern
);
  logic [15:0] lfsr;
  logic [15:0] raw;
  // LFSR restarts from the seed at each phase start so write and read sequences line up
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else if (seed_load) lfsr <= LFSR_SEED;
    else if (step) lfsr <= lfsr_next(lfsr);
  end
  // pattern select, then whole-word inversion on odd looped passes
  always_comb begin
    raw = mode == MODE_ADDR ? addr : mode == MODE_NADDR ? ~addr : mode == MODE_LFSR ? lfsr : 16'h0001 << addr[3:0];
    pattern = raw ^ {16{invert}};
  end
endmodule

// File: rtl/sdram_memtest.sv
// sdram_memtest: write/readback pattern tester driving the sdram controller host port
module sdram_memtest
  import sdram_memtest_pkg::*;
#(
  parameter int          ADDR_W     = 24,
  parameter int          ADDR_LAST  = 255,
  parameter int          WRITE_WAIT = 2,
  parameter int          READ_WAIT  = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              loop,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic [1:0]        mem_ds,
  input  logic [15:0]       mem_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [15:0]       fail_exp,
  output logic [15:0]       fail_got,
  output logic [7:0]        pass_count
);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, addr_q;
  logic [7:0] cnt;
  logic [1:0] mode_q;
  logic inv, we_q;
  logic [15:0] pat, din_q;
  logic go, fire, last, wait_hit, rerun, seed_load, step;

  sdram_memtest_pattern #(.LFSR_SEED(LFSR_SEED)) u_pattern (
    .clk(clk), .reset(reset), .seed_load(seed_load), .step(step),
    .addr(addr[15:0]), .mode(mode_q), .invert(inv), .pattern(pat)
  );

  assign go = start && !busy && (state == IDLE || state == DONE);
  assign fire = clk_en && (state == WR_ISSUE || state == RD_ISSUE);
  assign last = addr == ADDR_W'(ADDR_LAST);
  assign wait_hit = clk_en && cnt == (state == WR_WAIT ? 8'(WRITE_WAIT - 1) : 8'(READ_WAIT - 1));
  assign rerun = state == DONE && busy && loop;
  // request is only raised in a cycle that is already an issue state, so it is exactly one strobe wide
  assign mem_req = fire;
  assign mem_we = fire ? state == WR_ISSUE : we_q;
  assign mem_addr = fire ? addr : addr_q;
  assign mem_din = fire ? pat : din_q;
  assign mem_ds = 2'b11;
  assign pass = done && err_count == 16'd0;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  // next state plus address/LFSR sequencing controls
  always_comb begin
    state_n = state;
    seed_load = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: if (go) begin state_n = WR_ISSUE; seed_load = 1'b1; end
      WR_ISSUE: if (fire) state_n = WR_WAIT;
      WR_WAIT: if (wait_hit) begin state_n = last ? RD_ISSUE : WR_ISSUE; seed_load = last; step = !last; end
      RD_ISSUE: if (fire) state_n = RD_WAIT;
      RD_WAIT: if (wait_hit) state_n = CHECK;
      CHECK: begin state_n = last ? DONE : RD_ISSUE; step = !last; end
      DONE: if (go || rerun) begin state_n = WR_ISSUE; seed_load = 1'b1; end
      default: state_n = IDLE;
    endcase
  end

  // datapath: address walk, wait counting, held bus values, result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= '0;
      addr_q <= '0;
      cnt <= 8'd0;
      mode_q <= 2'd0;
      inv <= 1'b0;
      we_q <= 1'b0;
      din_q <= 16'd0;
      busy <= 1'b0;
      done <= 1'b0;
      err_count <= 16'd0;
      fail_addr <= '0;
      fail_exp <= 16'd0;
      fail_got <= 16'd0;
      pass_count <= 8'd0;
    end else begin
      if (seed_load) addr <= '0;
      else if (step) addr <= addr + 1'b1;
      if ((state == WR_WAIT || state == RD_WAIT) && clk_en) cnt <= wait_hit ? 8'd0 : cnt + 8'd1;
      if (fire) begin
        we_q <= state == WR_ISSUE;
        addr_q <= addr;
        din_q <= pat;
      end
      if (state == CHECK) begin
        if (mem_dout != pat) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          if (err_count == 16'd0) begin
            fail_addr <= addr;
            fail_exp <= pat;
            fail_got <= mem_dout;
          end
        end
        if (last) begin
          done <= 1'b1;
          pass_count <= pass_count + 8'd1;
          busy <= loop;
        end
      end
      if (state == DONE && busy && !loop) busy <= 1'b0;
      if (rerun) begin
        inv <= ~inv;
        done <= 1'b0;
      end
      if (go) begin
        mode_q <= mode;
        inv <= 1'b0;
        busy <= 1'b1;
        done <= 1'b0;
        err_count <= 16'd0;
        fail_addr <= '0;
        fail_exp <= 16'd0;
        fail_got <= 16'd0;
      end
    end
  end
endmodule

// File: tb/tb_sdram_memtest.sv
// tb_sdram_memtest: scoreboard bench for sdram_memtest with an ideal memory model
module tb_sdram_memtest;
  typedef struct {logic we; logic [23:0] addr; logic [15:0] din;} acc_t;
  typedef struct {logic [15:0] err; logic [23:0] fa; logic [15:0] fe; logic [15:0] fg; logic [7:0] pc; int left;} st_t;

  logic clk = 1'b0;
  logic clk_en;
  logic [2:0] ph = 3'd0;
  int cyc = 0;
  logic rst [2], start [2], loop [2], mem_req [2], mem_we [2], busy [2], done [2], pass [2];
  logic [1:0] mode [2], mem_ds [2];
  logic [23:0] mem_addr [2], fail_addr [2];
  logic [15:0] mem_din [2], mem_dout [2], err_count [2], fail_exp [2], fail_got [2], stuck [2];
  logic [7:0] pass_count [2];
  logic [15:0] mem [2][256];
  logic req_prev [2], done_prev [2];
  logic [15:0] lfsr_tab [4];
  acc_t acc_q [$];
  st_t st_q [$];
  int n_chk = 0, n_fail = 0;

  sdram_memtest #(.ADDR_LAST(255)) u_big (
    .clk(clk), .reset(rst[0]), .clk_en(clk_en), .start(start[0]), .mode(mode[0]), .loop(loop[0]),
    .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]),
    .mem_ds(mem_ds[0]), .mem_dout(mem_dout[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err_count[0]), .fail_addr(fail_addr[0]), .fail_exp(fail_exp[0]), .fail_got(fail_got[0]),
    .pass_count(pass_count[0])
  );
  sdram_memtest #(.ADDR_LAST(3)) u_small (
    .clk(clk), .reset(rst[1]), .clk_en(clk_en), .start(start[1]), .mode(mode[1]), .loop(loop[1]),
    .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]),
    .mem_ds(mem_ds[1]), .mem_dout(mem_dout[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err_count[1]), .fail_addr(fail_addr[1]), .fail_exp(fail_exp[1]), .fail_got(fail_got[1]),
    .pass_count(pass_count[1])
  );

  always #5 clk = ~clk;
  assign clk_en = ph == 3'd0;

  // strobe phase, cycle count and a 1-cycle-latency memory with optional stuck-at-0 bits
  always @(posedge clk) begin
    ph <= ph + 3'd1;
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++)
      if (mem_req[i]) begin
        if (mem_we[i]) mem[i][mem_addr[i][7:0]] <= mem_din[i] & ~stuck[i];
        else mem_dout[i] <= mem[i][mem_addr[i][7:0]];
      end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic mon(input int i);
    acc_t e;
    st_t s;
    if (rst[i]) begin
      req_prev[i] = 1'b0;
      done_prev[i] = 1'b0;
      return;
    end
    if (mem_req[i]) begin
      chk("req_on_clk_en", 32'(clk_en), 32'd1);
      chk("req_one_cycle", 32'(req_prev[i]), 32'd0);
      if (acc_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_access: inst %0d got access at addr %h, expected none", i, mem_addr[i]);
      end else begin
        e = acc_q.pop_front();
        chk("mem_we", 32'(mem_we[i]), 32'(e.we));
        chk("mem_addr", 32'(mem_addr[i]), 32'(e.addr));
        if (e.we) chk("mem_din", 32'(mem_din[i]), 32'(e.din));
      end
    end
    if (done[i] && !done_prev[i]) begin
      if (st_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_done: inst %0d got done, expected none", i);
      end else begin
        s = st_q.pop_front();
        chk("pass", 32'(pass[i]), 32'(s.err == 16'd0));
        chk("err_count", 32'(err_count[i]), 32'(s.err));
        chk("fail_addr", 32'(fail_addr[i]), 32'(s.fa));
        chk("fail_exp", 32'(fail_exp[i]), 32'(s.fe));
        chk("fail_got", 32'(fail_got[i]), 32'(s.fg));
        chk("pass_count", 32'(pass_count[i]), 32'(s.pc));
        chk("accesses_left", 32'(acc_q.size()), 32'(s.left));
        chk("mem_ds", 32'(mem_ds[i]), 32'd3);
      end
    end
    req_prev[i] = mem_req[i];
    done_prev[i] = done[i];
  endtask

  // scoreboard monitor: compares every request and every done rising edge
  always @(negedge clk) for (int i = 0; i < 2; i++) mon(i);

  task automatic push_pass(input int last, input logic [1:0] m, input logic [15:0] x);
    logic [15:0] d;
    for (int w = 0; w < 2; w++)
      for (int a = 0; a <= last; a++) begin
        d = m == 2'd0 ? 16'(a) : m == 2'd2 ? lfsr_tab[a % 4] : 16'h0001 << a[3:0];
        acc_q.push_back('{w == 0, 24'(a), d ^ x});
      end
  endtask

  task automatic push_st(input logic [15:0] err, input logic [23:0] fa, input logic [15:0] fe,
                         input logic [15:0] fg, input logic [7:0] pc, input int left);
    st_q.push_back('{err, fa, fe, fg, pc, left});
  endtask

  task automatic kick(input int i, input logic [1:0] m, input logic lp, input bit align, output int sc);
    @(negedge clk);
    if (align) while (!clk_en) @(negedge clk);
    mode[i] = m;
    loop[i] = lp;
    start[i] = 1'b1;
    sc = cyc;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (st_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (st_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: %0d results pending after %0d cycles, expected 0", st_q.size(), budget);
      st_q.delete();
    end
    acc_q.delete();
  endtask

  initial begin
    int sc, k, drop;
    logic busy_low;
    lfsr_tab = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C};
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; loop[i] = 1'b0; mode[i] = 2'd0;
      stuck[i] = 16'd0; mem_dout[i] = 16'd0; req_prev[i] = 1'b0; done_prev[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_mem_ds", 32'(mem_ds[0]), 32'd3);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_pass", 32'(pass[0]), 32'd0);
    chk("rst_err", 32'(err_count[0]), 32'd0);
    chk("rst_pass_count", 32'(pass_count[0]), 32'd0);
    chk("rst_req", 32'(mem_req[0]), 32'd0);
    chk("rst_addr", 32'(mem_addr[0]), 32'd0);
    chk("rst_din", 32'(mem_din[0]), 32'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    push_pass(255, 2'd0, 16'h0000);
    push_st(16'd0, 24'd0, 16'd0, 16'd0, 8'd1, 0);
    kick(0, 2'd0, 1'b0, 1'b0, sc);
    repeat (100) @(negedge clk);
    mode[0] = 2'd1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    mode[0] = 2'd0;
    wait_done(14000);
    repeat (2) @(negedge clk);
    chk("done_hold", 32'(done[0]), 32'd1);
    chk("busy_clear", 32'(busy[0]), 32'd0);

    stuck[0] = 16'h0008;
    push_pass(255, 2'd0, 16'h0000);
    push_st(16'd128, 24'd8, 16'h0008, 16'h0000, 8'd2, 0);
    kick(0, 2'd0, 1'b0, 1'b0, sc);
    wait_done(14000);
    stuck[0] = 16'd0;

    push_pass(3, 2'd2, 16'h0000);
    push_st(16'd0, 24'd0, 16'd0, 16'd0, 8'd1, 0);
    kick(1, 2'd2, 1'b0, 1'b1, sc);
    k = 0;
    while (!mem_req[1] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("first_write_delay", 32'(cyc - sc), 32'd8);
    wait_done(2000);

    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    push_pass(3, 2'd3, 16'h0000);
    push_pass(3, 2'd3, 16'hFFFF);
    push_pass(3, 2'd3, 16'h0000);
    push_st(16'd0, 24'd0, 16'd0, 16'd0, 8'd1, 16);
    push_st(16'd0, 24'd0, 16'd0, 16'd0, 8'd2, 8);
    push_st(16'd0, 24'd0, 16'd0, 16'd0, 8'd3, 0);
    kick(1, 2'd3, 1'b1, 1'b0, sc);
    busy_low = 1'b0;
    k = 0;
    drop = 0;
    while (pass_count[1] != 8'd3 && k < 4000) begin
      if (!busy[1]) busy_low = 1'b1;
      if (pass_count[1] == 8'd2) begin
        drop++;
        if (drop == 3) loop[1] = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    chk("loop_busy_low", 32'(busy_low), 32'd0);
    wait_done(500);

    push_pass(3, 2'd0, 16'h0000);
    kick(1, 2'd0, 1'b0, 1'b0, sc);
    k = 0;
    while (!(mem_req[1] && !mem_we[1]) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    #1 rst[1] = 1'b1;
    #1;
    chk("midrst_req", 32'(mem_req[1]), 32'd0);
    chk("midrst_busy", 32'(busy[1]), 32'd0);
    chk("midrst_err", 32'(err_count[1]), 32'd0);
    chk("midrst_pass_count", 32'(pass_count[1]), 32'd0);
    acc_q.delete();
    st_q.delete();
    @(negedge clk);
    rst[1] = 1'b0;
    push_pass(3, 2'd0, 16'h0000);
    push_st(16'd0, 24'd0, 16'd0, 16'd0, 8'd1, 0);
    kick(1, 2'd0, 1'b0, 1'b0, sc);
    wait_done(2000);
    chk("clean_pass", 32'(pass[1]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
